// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM family.
// Build option: DPRAM_INIT_CLEAR_EN enables the post-reset memory clear sequencer.
package dpram_pkg;

    // Widest data word the generic lane-merge helper supports.
    localparam int unsigned DP_MAX_W = 1024;

    localparam int unsigned RD_OLD_DATA = 0;
    localparam int unsigned RD_NEW_DATA = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    function automatic int unsigned calc_nb(input int unsigned width, input int unsigned byte_w);
        return width / byte_w;
    endfunction

    function automatic logic [DP_MAX_W-1:0] byte_merge(
        input logic [DP_MAX_W-1:0] old_w,
        input logic [DP_MAX_W-1:0] new_w,
        input logic [DP_MAX_W-1:0] we,
        input int unsigned         byte_w
    );
        logic [DP_MAX_W-1:0] r;
        for (int unsigned b = 0; b < DP_MAX_W; b++) begin
            r[b] = we[b / byte_w] ? new_w[b] : old_w[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_port_out.sv
// Read-data / valid pipeline for one RAM port: optional output register, data held while idle.
module dpram_port_out #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data1_q, data1_d;
    logic             valid1_q, valid1_d;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        data1_d  = rd_en ? rd_data : data1_q;
        valid1_d = rd_en;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q  <= '0;
            valid1_q <= 1'b0;
        end else begin
            data1_q  <= data1_d;
            valid1_q <= valid1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] data2_q, data2_d;
        logic             valid2_q, valid2_d;

        always_comb begin
            data2_d  = valid1_q ? data1_q : data2_q;
            valid2_d = valid1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data2_q  <= '0;
                valid2_q <= 1'b0;
            end else begin
                data2_q  <= data2_d;
                valid2_q <= valid2_d;
            end
        end

        assign dout  = data2_q;
        assign valid = valid2_q;
    end else begin : g_no_out_reg
        assign dout  = data1_q;
        assign valid = valid1_q;
    end

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, collision flag and read-mode select.
// Build option: DPRAM_INIT_CLEAR_EN adds a post-reset sequencer that zeroes every word.
module dpram_be_clr
    import dpram_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned DEPTH   = 16,
    parameter  int unsigned BYTE_W  = 8,
    parameter  int unsigned RD_MODE = RD_OLD_DATA,
    parameter  int unsigned OUT_REG = 0,
    localparam int unsigned NB      = calc_nb(WIDTH, BYTE_W),
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             init_busy,
    input  logic             ena,
    input  logic [NB-1:0]    wea,
    input  logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] dina,
    output logic [WIDTH-1:0] douta,
    output logic             valida,
    input  logic             enb,
    input  logic [NB-1:0]    web,
    input  logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] dinb,
    output logic [WIDTH-1:0] doutb,
    output logic             validb,
    output logic             collision
);

    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    we
    );
        return WIDTH'(byte_merge(DP_MAX_W'(old_w), DP_MAX_W'(new_w), DP_MAX_W'(we), BYTE_W));
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             ready;

`ifdef DPRAM_INIT_CLEAR_EN
    init_state_e   state_q, state_d;
    logic [AW-1:0] clear_addr_q, clear_addr_d;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        if (state_q == ST_CLEAR) begin
            clear_addr_d = clear_addr_q + AW'(1);
            if (clear_addr_q == AW'(DEPTH - 1)) begin
                state_d      = ST_READY;
                clear_addr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    assign ready = (state_q == ST_READY);
`else
    assign ready = 1'b1;
`endif

    assign init_busy = !ready;

    logic             ok_a, ok_b, req_a, req_b, wr_a, wr_b, same_addr, overlap;
    logic [WIDTH-1:0] old_a, old_b, new_a, new_b, both_w, rd_a, rd_b;
    logic             collision_q, collision_d;

    always_comb begin
        ok_a      = 32'(addra) < DEPTH;
        ok_b      = 32'(addrb) < DEPTH;
        req_a     = ready && ena;
        req_b     = ready && enb;
        wr_a      = req_a && ok_a && (|wea);
        wr_b      = req_b && ok_b && (|web);
        same_addr = (addra == addrb);
        old_a     = ok_a ? mem_q[addra] : '0;
        old_b     = ok_b ? mem_q[addrb] : '0;
        new_a     = lane_merge(old_a, dina, wea);
        new_b     = lane_merge(old_b, dinb, web);
        // A is merged last so it owns every lane both ports enable.
        both_w    = lane_merge(new_b, dina, wea);
        overlap   = wr_a && wr_b && same_addr && (|(wea & web));
        rd_a      = (RD_MODE == RD_NEW_DATA && ok_a) ? new_a : old_a;
        rd_b      = (RD_MODE == RD_NEW_DATA && ok_b) ? new_b : old_b;
        collision_d = overlap;
    end

    // NOTE: the array has no reset branch; an async reset would turn the RAM into plain flops.
    always_ff @(posedge clk) begin
`ifdef DPRAM_INIT_CLEAR_EN
        if (state_q == ST_CLEAR) mem_q[clear_addr_q] <= '0;
`endif
        if (wr_a && wr_b && same_addr) begin
            mem_q[addra] <= both_w;
        end else begin
            if (wr_a) mem_q[addra] <= new_a;
            if (wr_b) mem_q[addrb] <= new_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) collision_q <= 1'b0;
        else        collision_q <= collision_d;
    end

    assign collision = collision_q;

    dpram_port_out #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_out_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (req_a),
        .rd_data (rd_a),
        .dout    (douta),
        .valid   (valida)
    );

    dpram_port_out #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_out_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (req_b),
        .rd_data (rd_b),
        .dout    (doutb),
        .valid   (validb)
    );

endmodule

// File: doc/dpram_be_clr.md
Name: dpram_be_clr

Overview:
Parametrised single-clock true dual-port RAM. Next generation of the team's DPRAM.
- Adds per-byte write enables, a selectable read-during-write mode, and an optional output register stage.
- Adds deterministic write-collision resolution with a flag, and a post-reset memory-clear sequencer.
- Used as a general scratchpad/buffer wherever two agents share one clock domain.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of BYTE_W.
DEPTH, 16, number of words; need not be a power of two.
BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W.
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
OUT_REG, 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2 cycles.

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
init_busy  out  1  high while the clear sequencer runs; port requests are ignored
ena  in  1  port A enable
wea  in  NB  port A byte write enables
addra  in  $clog2(DEPTH)  port A address
dina  in  WIDTH  port A write data
douta  out  WIDTH  port A read data
valida  out  1  douta carries data for a read issued this-latency ago
enb, web, addrb, dinb, doutb, validb  same as port A, for port B
collision  out  1  registered pulse: both ports wrote overlapping bytes of the same address

Behaviour:
- Reset (async, rst_n=0):
  - douta = doutb = 0; valida = validb = 0; collision = 0; init_busy = 1.
  - Sequencer enters CLEAR with clear address 0.
  - Memory contents are not reset asynchronously.
- Sequencer FSM, states CLEAR and READY:
  - CLEAR writes 0 to clear_addr each cycle and increments it.
  - After writing DEPTH-1, the next state is READY. init_busy falls on that edge, so it is high for exactly DEPTH cycles after rst_n rises.
  - In CLEAR: all port enables are ignored (no writes, valid = 0), and outputs hold 0.
- Reset mid-operation:
  - Async clear of all outputs and the FSM.
  - Any pipeline contents are discarded and CLEAR restarts from address 0 after release.
- Write: en=1 and we[i]=1 writes din[i*BYTE_W +: BYTE_W] to mem[addr] lane i on the clock edge. Lanes with we[i]=0 are untouched.
- Read:
  - Every cycle with en=1 (any we) is a read of mem[addr].
  - Data appears on dout with valid=1 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
  - valid is a single-cycle pulse per request. Back-to-back requests give one valid per cycle.
- en=0: dout holds its last value; valid = 0.
- Same-port read-during-write:
  - RD_MODE=0: dout returns the pre-write word.
  - RD_MODE=1: dout returns the merged word (written lanes new, other lanes old).
- Cross-port read of an address the other port writes in the same cycle: the reader always gets the pre-write word.
- Write collision (both write the same address in the same cycle):
  - Per lane, port A wins where both we bits are set. Lanes enabled on only one port take that port's data.
  - collision = 1 on the following cycle for one cycle, only if at least one lane overlapped.
- Out-of-range address (addr >= DEPTH): write is dropped; a read returns 0 with valid = 1; no collision is flagged.

Optional Feature:
DPRAM_INIT_CLEAR_EN
- Defined: CLEAR sequencer as above.
- Undefined:
  - No sequencer; init_busy is tied 0 and the block enters READY immediately after reset.
  - Memory is uninitialised (X in simulation).
  - All other behaviour is unchanged.

Decomposition:
- Package dpram_pkg holds:
  - FSM state typedef (CLEAR, READY);
  - a function computing NB from WIDTH/BYTE_W;
  - a function doing the per-lane byte-merge (old, new, we);
  - RD_MODE encoding constants.
- One sub-module, dpram_port_out: read-data and valid pipeline for one port (OUT_REG stage, hold-on-idle). It is instantiated once per port.

Test Plan:
- Clear: release rst_n with DPRAM_INIT_CLEAR_EN, DEPTH=16 -> init_busy high exactly 16 cycles; writes issued during that window are dropped; subsequent reads of all addresses return 0.
- Byte write: port A writes addr 3 = 0xA5A5A5A5 (wea=4'hF), then wea=4'b0010 with din 0x00003C00 -> read of addr 3 on port B returns 0xA5A53CA5, valid after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Read-during-write: addr 5 holds 0x11111111; port A writes 0x22222222 with wea=F -> douta = 0x11111111 (RD_MODE=0) or 0x22222222 (RD_MODE=1); a simultaneous port B read of addr 5 gives 0x11111111.
- Collision: both ports write addr 7 in the same cycle, A=0xAAAAAAAA wea=4'b0011, B=0xBBBBBBBB web=4'b0110 -> mem[7] = 0x00BBAAAA from cleared state; collision pulses one cycle. A repeat with disjoint lanes gives no pulse.
- Back-to-back: port B reads addrs 0..3 on consecutive cycles -> four consecutive validb pulses carrying the matching data; doutb holds the last value after enb drops.
- Mid-op reset: assert rst_n low during a read burst -> douta, doutb and valid go 0 immediately; after release, init_busy high for DEPTH cycles again.
